// File: rtl/envelope_vca.sv
// ADSR amplitude envelope with an 8-bit PWM output stage.
// Gate edges retrigger or release the envelope; level chops the oscillator.
module envelope_vca #(
    parameter logic [15:0] PRESCALE     = 16'd1000,
    parameter logic [7:0]  ATTACK_STEP  = 8'd4,
    parameter logic [7:0]  DECAY_STEP   = 8'd1,
    parameter logic [7:0]  SUSTAIN      = 8'd160,
    parameter logic [7:0]  RELEASE_STEP = 8'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gate,
    input  logic       osc_in,
    output logic [7:0] level,
    output logic [2:0] state,
    output logic       pwmout
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  level_q, level_d;
    logic [15:0] presc_q, presc_d;
    logic [7:0]  pwm_cnt_q;
    logic        gate_q;
    logic        pwm_q, pwm_d;

    logic       tick;
    logic       rise;
    logic       fall;
    logic       fall_act;
    logic [8:0] att_sum;
    logic [8:0] dec_lim;

    assign tick    = (presc_q == PRESCALE - 16'd1);
    assign presc_d = tick ? 16'd0 : presc_q + 16'd1;

    assign rise = gate & ~gate_q;
    assign fall = ~gate & gate_q;

    assign att_sum = {1'b0, level_q} + {1'b0, ATTACK_STEP};
    assign dec_lim = {1'b0, SUSTAIN} + {1'b0, DECAY_STEP};

    // A fall only counts as an event while the note is still sounding.
    assign fall_act = fall && (state_q == S_ATTACK ||
                               state_q == S_DECAY  ||
                               state_q == S_SUSTAIN);

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (rise) begin
            state_d = S_ATTACK;
        end else if (fall_act) begin
            state_d = S_RELEASE;
        end else if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    level_d = 8'd0;
                end
                S_ATTACK: begin
                    if (att_sum >= 9'd255) begin
                        level_d = 8'd255;
                        state_d = S_DECAY;
                    end else begin
                        level_d = att_sum[7:0];
                    end
                end
                S_DECAY: begin
                    if ({1'b0, level_q} <= dec_lim) begin
                        level_d = SUSTAIN;
                        state_d = S_SUSTAIN;
                    end else begin
                        level_d = level_q - DECAY_STEP;
                    end
                end
                S_SUSTAIN: begin
                    level_d = SUSTAIN;
                end
                S_RELEASE: begin
                    if (level_q <= RELEASE_STEP) begin
                        level_d = 8'd0;
                        state_d = S_IDLE;
                    end else begin
                        level_d = level_q - RELEASE_STEP;
                    end
                end
                default: begin
                    level_d = 8'd0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign pwm_d = osc_in & (pwm_cnt_q < level_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            level_q   <= 8'd0;
            presc_q   <= 16'd0;
            pwm_cnt_q <= 8'd0;
            gate_q    <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            gate_q    <= gate;
            pwm_q     <= pwm_d;
        end
    end

    assign level  = level_q;
    assign state  = state_q;
    assign pwmout = pwm_q;

endmodule

// File: tb/tb_envelope_vca.sv
// Directed bench for envelope_vca: envelope sequencing, retrigger,
// early release, tick/event collision, mid-run reset and PWM duty.
module tb_envelope_vca;

    logic       clk;
    logic       rst;
    logic       gate;
    logic       osc;
    logic [7:0] level;
    logic [2:0] state;
    logic       pwmout;

    logic       gate2;
    logic       osc2;
    logic [7:0] level2;
    logic [2:0] state2;
    logic       pwm2;

    int n_cmp;
    int n_err;

    envelope_vca #(
        .PRESCALE    (16'd4),
        .ATTACK_STEP (8'd64),
        .DECAY_STEP  (8'd16),
        .SUSTAIN     (8'd128),
        .RELEASE_STEP(8'd32)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .gate  (gate),
        .osc_in(osc),
        .level (level),
        .state (state),
        .pwmout(pwmout)
    );

    envelope_vca #(
        .PRESCALE    (16'd4),
        .ATTACK_STEP (8'd64),
        .DECAY_STEP  (8'd16),
        .SUSTAIN     (8'd64),
        .RELEASE_STEP(8'd32)
    ) u_pwm (
        .clk   (clk),
        .rst   (rst),
        .gate  (gate2),
        .osc_in(osc2),
        .level (level2),
        .state (state2),
        .pwmout(pwm2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_ls(input string tag, input int lv, input int st);
        chk({tag, "_level"}, int'(level), lv);
        chk({tag, "_state"}, int'(state), st);
    endtask

    int dec_exp[8] = '{239, 223, 207, 191, 175, 159, 143, 128};
    int rel_exp[4] = '{96, 64, 32, 0};
    int cnt;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        gate  = 1'b1;
        osc   = 1'b1;
        gate2 = 1'b0;
        osc2  = 1'b1;

        // reset with gate held high
        step(1);
        chk_ls("rst1", 0, 0);
        chk("rst1_pwm", int'(pwmout), 0);
        step(2);
        chk_ls("rst3", 0, 0);
        chk("rst3_pwm", int'(pwmout), 0);
        rst = 1'b0;

        // first edge after release sees the rise; tick on the 4th edge
        step(1);
        chk_ls("rise", 0, 1);
        step(2);
        chk_ls("pretick", 0, 1);
        step(1);
        chk_ls("att1", 64, 1);
        step(4);
        chk_ls("att2", 128, 1);
        step(4);
        chk_ls("att3", 192, 1);
        step(4);
        chk_ls("att4", 255, 2);
        for (int i = 0; i < 8; i++) begin
            step(4);
            chk_ls($sformatf("dec%0d", i), dec_exp[i], (i == 7) ? 3 : 2);
        end

        // release from sustain; last tick was on the edge just taken
        gate = 1'b0;
        step(1);
        chk_ls("fall", 128, 4);
        step(3);
        chk_ls("rel0", rel_exp[0], 4);
        step(4);
        chk_ls("rel1", rel_exp[1], 4);

        // legato retrigger at level 64
        gate = 1'b1;
        step(1);
        chk_ls("retrig", 64, 1);
        step(3);
        chk_ls("retrig_tick", 128, 1);

        // early release in attack at 128
        gate = 1'b0;
        step(1);
        chk_ls("early", 128, 4);
        step(3);
        chk_ls("early_tick", 96, 4);

        // rise lands on a tick edge: level must hold
        step(3);
        chk_ls("pre_coll", 96, 4);
        gate = 1'b1;
        step(1);
        chk_ls("coll", 96, 1);
        step(4);
        chk_ls("coll_next", 160, 1);
        step(4);
        chk_ls("att_b", 224, 1);
        step(4);
        chk_ls("att_c", 255, 2);
        step(12);
        chk_ls("dec_207", 207, 2);

        // mid-operation reset in decay
        rst = 1'b1;
        step(1);
        chk_ls("midrst", 0, 0);
        chk("midrst_pwm", int'(pwmout), 0);
        rst = 1'b0;
        step(1);
        chk_ls("midrst_rise", 0, 1);
        step(2);
        chk_ls("midrst_pre", 0, 1);
        step(1);
        chk_ls("midrst_tick", 64, 1);

        // PWM: idle gives no output even with osc high
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (pwm2) cnt++;
        end
        chk("pwm_idle", cnt, 0);

        gate2 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (state2 == 3'd3) break;
        end
        chk("pwm_reach_sus", int'(state2), 3);
        chk("pwm_sus_level", int'(level2), 64);

        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (pwm2) cnt++;
        end
        chk("pwm_duty64", cnt, 64);

        osc2 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (pwm2) cnt++;
        end
        chk("pwm_osc0", cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
